// File: rtl/fft_magnitude_if.sv
// Butterfly-memory read port and output stream of fft_magnitude.
// master: the magnitude engine; slave: the memory plus the downstream sink.
`timescale 1ns/1ps
interface fft_magnitude_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 7
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_re;
    logic signed [DATA_W-1:0] rd_im;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last,
        input  rd_re, rd_im, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last,
        output rd_re, rd_im, out_ready
    );
endinterface

// File: rtl/fft_magnitude.sv
// Alpha-max-beta-min magnitude of the first NUM_BINS FFT bins, streamed through a credit-limited FIFO.
// Optional FFT_MAG_DC_BLOCK_EN forces the bin-0 magnitude to zero.
`timescale 1ns/1ps
module fft_magnitude #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 16,
    parameter int NUM_BINS   = 64,
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      stage_select,
    fft_magnitude_if.master bus,
    output logic            busy,
    output logic            done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = DATA_W + 1;
    localparam int EXT_W = (OUT_W > SUM_W) ? OUT_W : SUM_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
    localparam logic [EXT_W-1:0]  SAT_MAX   = EXT_W'({OUT_W{1'b1}});

    logic [1:0]        state_q, state_d;
    logic              mag_phase, mag_phase_q, start_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_acc_q, last_acc_d;

    logic              v1_q, last1_q;
    logic              v2_q, last2_q;
    logic [DATA_W-1:0] abs_re_q, abs_re_d;
    logic [DATA_W-1:0] abs_im_q, abs_im_d;
`ifdef FFT_MAG_DC_BLOCK_EN
    logic              first1_q, first2_q;
`endif

    logic [OUT_W-1:0]      fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic              issue, push, pop, out_valid;
    logic [CNT_W:0]    occupancy;
    logic [DATA_W-1:0] re_u, im_u, mag_max, mag_min;
    logic [SUM_W-1:0]  sum;
    logic [EXT_W-1:0]  sum_ext;
    logic [OUT_W-1:0]  mag;

    assign mag_phase = (stage_select == 4'd15);

    // Credits cover the FIFO plus both pipeline stages, so a push never meets a full FIFO.
    assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(v1_q) + (CNT_W+1)'(v2_q);
    assign issue     = (state_q == READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = v2_q;
    assign pop       = out_valid && bus.out_ready;

    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign busy          = (state_q == READ) || (state_q == DRAIN);
    assign done          = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_acc_d = last_acc_q;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d    = READ;
                    addr_d     = '0;
                    last_acc_d = 1'b0;
                end
            end
            READ: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (pop && bus.out_last) last_acc_d = 1'b1;
                if (!v1_q && !v2_q && (count_q == '0) && last_acc_q) begin
                    state_d = DONE;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_acc_q  <= 1'b0;
            mag_phase_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_acc_q  <= last_acc_d;
            mag_phase_q <= mag_phase;
            start_q     <= mag_phase && !mag_phase_q;
        end
    end

    always_comb begin
        re_u     = bus.rd_re;
        im_u     = bus.rd_im;
        abs_re_d = re_u[DATA_W-1] ? (~re_u + DATA_W'(1)) : re_u;
        abs_im_d = im_u[DATA_W-1] ? (~im_u + DATA_W'(1)) : im_u;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            abs_re_q <= '0;
            abs_im_q <= '0;
        end else begin
            v1_q    <= issue;
            last1_q <= issue && (addr_q == LAST_ADDR);
            v2_q    <= v1_q;
            last2_q <= last1_q;
            if (v1_q) begin
                abs_re_q <= abs_re_d;
                abs_im_q <= abs_im_d;
            end
        end
    end

`ifdef FFT_MAG_DC_BLOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first1_q <= 1'b0;
            first2_q <= 1'b0;
        end else begin
            first1_q <= issue && (addr_q == '0);
            first2_q <= first1_q;
        end
    end
`endif

    always_comb begin
        mag_max = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
        mag_min = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
        sum     = SUM_W'(mag_max) + SUM_W'(mag_min >> 2) + SUM_W'(mag_min >> 3);
        sum_ext = EXT_W'(sum);
        mag     = (sum_ext > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : sum_ext[OUT_W-1:0];
`ifdef FFT_MAG_DC_BLOCK_EN
        if (first2_q) mag = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mag;
            fifo_last_q[wr_ptr_q] <= last2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
    a_addr_range: assert property (@(posedge clk) disable iff (rst)
        addr_q <= LAST_ADDR);
endmodule

// File: tb/tb_fft_magnitude.sv
// Self-checking bench for fft_magnitude against a behavioural magnitude model.
`timescale 1ns/1ps
module tb_fft_magnitude;
    localparam int DATA_W     = 16;
    localparam int OUT_W      = 16;
    localparam int NUM_BINS   = 64;
    localparam int ADDR_W     = 7;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stage_select = 4'd0;
    logic       busy, done;

    fft_magnitude_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    fft_magnitude #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_BINS(NUM_BINS),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stage_select(stage_select),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int re_mem [NUM_BINS];
    int im_mem [NUM_BINS];

    // Butterfly memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_re <= DATA_W'(re_mem[bus.rd_addr]);
            bus.rd_im <= DATA_W'(im_mem[bus.rd_addr]);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int ref_mag(input int re, input int im, input int bin);
        int a, b, mx, mn, s;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        s  = mx + mn / 4 + mn / 8;
        if (s > (1 << OUT_W) - 1) s = (1 << OUT_W) - 1;
`ifdef FFT_MAG_DC_BLOCK_EN
        if (bin == 0) s = 0;
`endif
        return s;
    endfunction

    int q_data [$];
    bit q_last [$];
    int q_addr [$];
    int rden_first, valid_first, rden_window, done_count, stall_viol, probe_data;
    bit probe_valid;

    // mode 0: always ready; 1: not ready before stall_cyc; 2: random ready
    task automatic run_cycles(input int ncyc, input int mode, input int stall_cyc,
                              input int glitch_at, input int probe_at);
        bit held;
        int held_data;
        q_data.delete(); q_last.delete(); q_addr.delete();
        rden_first = -1; valid_first = -1; rden_window = 0; done_count = 0;
        stall_viol = 0; probe_data = -1; probe_valid = 0; held = 0; held_data = 0;
        stage_select = 4'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < ncyc; i++) begin
            if (i != 0) @(negedge clk);
            if (i == 0) stage_select = 4'd15;
            if (glitch_at > 0 && i == glitch_at)     stage_select = 4'd14;
            if (glitch_at > 0 && i == glitch_at + 1) stage_select = 4'd15;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (i >= stall_cyc);
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (bus.rd_en) begin
                q_addr.push_back(int'(bus.rd_addr));
                if (rden_first < 0) rden_first = i;
                if (i < stall_cyc) rden_window++;
            end
            if (bus.out_valid && valid_first < 0) valid_first = i;
            if (held && int'(bus.out_data) != held_data) stall_viol++;
            held      = bus.out_valid && !bus.out_ready;
            held_data = int'(bus.out_data);
            if (i == probe_at) begin
                probe_valid = bus.out_valid;
                probe_data  = int'(bus.out_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                q_data.push_back(int'(bus.out_data));
                q_last.push_back(bus.out_last);
            end
            if (done) done_count++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        stage_select = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); else n_pass++;
        n_checks++; if (bus.rd_addr !== 7'd0) $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 16'd0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", bus.out_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int addr_err;
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = 100;
            im_mem[i] = -40;
        end
        run_cycles(120, 0, 0, 0, -1);
        n_checks++; if (rden_first != 2) $display("FAIL basic_first_rd_en: got cycle %0d want 2", rden_first); else n_pass++;
        n_checks++; if (valid_first != rden_first + 3) $display("FAIL basic_latency: got cycle %0d want %0d", valid_first, rden_first + 3); else n_pass++;
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL basic_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        for (int i = 0; i < NUM_BINS && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] != ref_mag(100, -40, i) || q_last[i] != (i == NUM_BINS - 1))
                $display("FAIL basic_beat%0d: got %0d/last %b want %0d/last %b",
                         i, q_data[i], q_last[i], ref_mag(100, -40, i), i == NUM_BINS - 1);
            else n_pass++;
        end
        addr_err = 0;
        for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] != i) addr_err++;
        n_checks++; if (q_addr.size() != NUM_BINS || addr_err != 0) $display("FAIL basic_addr_order: got %0d reads %0d misordered want %0d/0", q_addr.size(), addr_err, NUM_BINS); else n_pass++;
        n_checks++; if (done_count != 1) $display("FAIL basic_done: got %0d pulses want 1", done_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.rd_addr !== 7'd0) $display("FAIL basic_addr_after: got %0d want 0", bus.rd_addr); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = int'($urandom_range(0, 65535)) - 32768;
            im_mem[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        re_mem[5] = -32768; im_mem[5] = -32768;
        re_mem[6] = 0;      im_mem[6] = 0;
        re_mem[7] = 32767;  im_mem[7] = -32768;
        run_cycles(400, 2, 0, 0, -1);
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL random_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        for (int i = 0; i < NUM_BINS && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] != ref_mag(re_mem[i], im_mem[i], i) || q_last[i] != (i == NUM_BINS - 1))
                $display("FAIL random_beat%0d: got %0d/last %b want %0d/last %b",
                         i, q_data[i], q_last[i], ref_mag(re_mem[i], im_mem[i], i), i == NUM_BINS - 1);
            else n_pass++;
        end
        if (q_data.size() > 7) begin
            n_checks++; if (q_data[5] != 45056) $display("FAIL random_min_neg: got %0d want 45056", q_data[5]); else n_pass++;
            n_checks++; if (q_data[6] != 0) $display("FAIL random_zero: got %0d want 0", q_data[6]); else n_pass++;
        end
        n_checks++; if (stall_viol != 0) $display("FAIL random_hold: got %0d unstable cycles want 0", stall_viol); else n_pass++;
        n_checks++; if (done_count != 1) $display("FAIL random_done: got %0d pulses want 1", done_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = i * 500 - 15000;
            im_mem[i] = 7000 - i * 211;
        end
        run_cycles(220, 1, 60, 0, 40);
        n_checks++; if (rden_window != FIFO_DEPTH) $display("FAIL bp_reads_stalled: got %0d reads want %0d", rden_window, FIFO_DEPTH); else n_pass++;
        n_checks++;
        if (probe_valid !== 1'b1 || probe_data != ref_mag(re_mem[0], im_mem[0], 0))
            $display("FAIL bp_head_hold: got valid %b data %0d want 1/%0d", probe_valid, probe_data, ref_mag(re_mem[0], im_mem[0], 0));
        else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", stall_viol); else n_pass++;
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL bp_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        for (int i = 0; i < NUM_BINS && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] != ref_mag(re_mem[i], im_mem[i], i) || q_last[i] != (i == NUM_BINS - 1))
                $display("FAIL bp_beat%0d: got %0d/last %b want %0d/last %b",
                         i, q_data[i], q_last[i], ref_mag(re_mem[i], im_mem[i], i), i == NUM_BINS - 1);
            else n_pass++;
        end
        n_checks++; if (done_count != 1) $display("FAIL bp_done: got %0d pulses want 1", done_count); else n_pass++;
    endtask

    task automatic test_retrigger();
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = -i * 300;
            im_mem[i] = i * 41 + 3;
        end
        run_cycles(300, 0, 0, 30, -1);
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL retrig_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        n_checks++; if (q_addr.size() != NUM_BINS) $display("FAIL retrig_reads: got %0d want %0d", q_addr.size(), NUM_BINS); else n_pass++;
        n_checks++; if (done_count != 1) $display("FAIL retrig_done: got %0d pulses want 1", done_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL retrig_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = i * 100;
            im_mem[i] = -(i * 37);
        end
        bus.out_ready = 1'b1;
        stage_select = 4'd0;
        repeat (2) @(negedge clk);
        stage_select = 4'd15;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.rd_en && bus.rd_addr == 7'd20) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL rstmid_reach_bin20: got timeout want rd_en at address 20"); else n_pass++;
        rst = 1'b1;
        stage_select = 4'd0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", bus.rd_en); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
        rst = 1'b0;
        run_cycles(150, 0, 0, 0, -1);
        n_checks++; if (q_addr.size() == 0 || q_addr[0] != 0) $display("FAIL rstmid_restart_addr: got %0d reads first %0d want first 0", q_addr.size(), q_addr.size() ? q_addr[0] : -1); else n_pass++;
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL rstmid_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        for (int i = 0; i < NUM_BINS && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] != ref_mag(re_mem[i], im_mem[i], i) || q_last[i] != (i == NUM_BINS - 1))
                $display("FAIL rstmid_beat%0d: got %0d/last %b want %0d/last %b",
                         i, q_data[i], q_last[i], ref_mag(re_mem[i], im_mem[i], i), i == NUM_BINS - 1);
            else n_pass++;
        end
        n_checks++; if (done_count != 1) $display("FAIL rstmid_done_after: got %0d pulses want 1", done_count); else n_pass++;
    endtask

    task automatic test_dc_block();
        int exp0;
        for (int i = 0; i < NUM_BINS; i++) begin
            re_mem[i] = 12000 - i * 150;
            im_mem[i] = i * 90 - 4000;
        end
`ifdef FFT_MAG_DC_BLOCK_EN
        exp0 = 0;
`else
        exp0 = 12000 + 4000 / 4 + 4000 / 8;
`endif
        run_cycles(120, 0, 0, 0, -1);
        n_checks++; if (q_data.size() == 0 || q_data[0] != exp0) $display("FAIL dc_beat0: got %0d want %0d", q_data.size() ? q_data[0] : -1, exp0); else n_pass++;
        n_checks++; if (q_data.size() != NUM_BINS) $display("FAIL dc_beats: got %0d want %0d", q_data.size(), NUM_BINS); else n_pass++;
        for (int i = 1; i < NUM_BINS && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] != ref_mag(re_mem[i], im_mem[i], i))
                $display("FAIL dc_beat%0d: got %0d want %0d", i, q_data[i], ref_mag(re_mem[i], im_mem[i], i));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_retrigger();
        test_reset_mid_frame();
        test_dc_block();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
